// File: rtl/dmem_arb_pkg.sv
// Shared types for the DataMemory arbiter: FSM states, port select, request bundle.
// Word-address helper strips the byte offset that DataMemory does not decode.
package dmem_arb_pkg;

    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_BE_W   = DMEM_DATA_W / 8;

    localparam logic [DMEM_BE_W-1:0] BE_FULL = '1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_sel_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [DMEM_BE_W-1:0]   be;
    } dmem_req_t;

    function automatic logic [DMEM_ADDR_W-1:0] word_addr(input logic [DMEM_ADDR_W-1:0] a);
        return {a[DMEM_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_be_merge.sv
// Per-byte-lane merge of a new store into the old memory word.
// Lanes with be set take the new data, the rest keep the old data.
module dmem_be_merge #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_data_i,
    input  logic [DATA_W-1:0]   new_data_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   merged_o
);

    always_comb begin
        merged_o = old_data_i;
        for (int i = 0; i < int'(DATA_W / 8); i++) begin
            if (be_i[i]) begin
                merged_o[8*i +: 8] = new_data_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DataMemory: fixed priority to the core
// port with starvation relief for the debug port, and RMW sequencing of partial stores.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                c_req,
    input  logic                c_we,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_be,
    output logic                c_gnt,
    output logic                c_rvalid,
    output logic [DATA_W-1:0]   c_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_write_data,
    output logic                mem_write_enable,
    output logic                mem_read_enable,
    input  logic [DATA_W-1:0]   mem_read_data
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                c_rvalid_q, c_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [ADDR_W-1:0]   rmw_addr_q, rmw_addr_d;
    logic [DATA_W-1:0]   rmw_data_q, rmw_data_d;

    logic                gnt_c, gnt_d, any_gnt;
    port_sel_e           sel_port;
    dmem_req_t           sel_req;
    logic                is_read, is_full_wr, is_part_wr;
    logic [DATA_W-1:0]   merged;

    // Grants are suppressed while reset is sampled so nothing is accepted into a reset edge.
    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (!rst && state_q == IDLE) begin
            if (d_req && (!c_req || starve_q == STARVE_LIMIT)) begin
                gnt_d = 1'b1;
            end else if (c_req) begin
                gnt_c = 1'b1;
            end
        end
    end

    assign any_gnt  = gnt_c | gnt_d;
    assign sel_port = gnt_d ? PORT_D : PORT_C;
    assign c_gnt    = gnt_c;
    assign d_gnt    = gnt_d;

    always_comb begin
        sel_req = '{we: c_we, addr: c_addr, wdata: c_wdata, be: c_be};
        unique case (sel_port)
            PORT_C: sel_req = '{we: c_we, addr: c_addr, wdata: c_wdata, be: c_be};
            PORT_D: sel_req = '{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be};
        endcase
    end

    assign is_read    = any_gnt && !sel_req.we;
    assign is_full_wr = any_gnt && sel_req.we && (sel_req.be == BE_FULL);
    assign is_part_wr = any_gnt && sel_req.we && (sel_req.be != BE_FULL) && (sel_req.be != '0);

    dmem_be_merge #(
        .DATA_W (DATA_W)
    ) u_be_merge (
        .old_data_i (mem_read_data),
        .new_data_i (sel_req.wdata),
        .be_i       (sel_req.be),
        .merged_o   (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
            rmw_addr_q <= '0;
            rmw_data_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
            rmw_addr_q <= rmw_addr_d;
            rmw_data_q <= rmw_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (is_part_wr) state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!d_req || gnt_d) begin
            starve_d = '0;
        end else if (gnt_c && starve_q != STARVE_LIMIT) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        c_rvalid_d = gnt_c && is_read;
        d_rvalid_d = gnt_d && is_read;
        c_rdata_d  = c_rvalid_d ? mem_read_data : c_rdata_q;
        d_rdata_d  = d_rvalid_d ? mem_read_data : d_rdata_q;

        rmw_addr_d = is_part_wr ? word_addr(sel_req.addr) : rmw_addr_q;
        rmw_data_d = is_part_wr ? merged : rmw_data_q;
    end

    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (any_gnt) begin
                        mem_address      = word_addr(sel_req.addr);
                        mem_read_enable  = is_read | is_part_wr;
                        mem_write_enable = is_full_wr;
                        if (is_full_wr) begin
                            mem_write_data = sel_req.wdata;
                        end
                    end
                end
                RMW_WR: begin
                    mem_address      = rmw_addr_q;
                    mem_write_data   = rmw_data_q;
                    mem_write_enable = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a DataMemory stand-in, a transaction-level reference model
// compared every cycle, and directed scenarios with hand-computed literal expectations.
module tb_dmem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [3:0]  c_be, d_be;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, mem_read_enable;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    dmem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .c_req            (c_req),
        .c_we             (c_we),
        .c_addr           (c_addr),
        .c_wdata          (c_wdata),
        .c_be             (c_be),
        .c_gnt            (c_gnt),
        .c_rvalid         (c_rvalid),
        .c_rdata          (c_rdata),
        .d_req            (d_req),
        .d_we             (d_we),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_be             (d_be),
        .d_gnt            (d_gnt),
        .d_rvalid         (d_rvalid),
        .d_rdata          (d_rdata),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory stand-in: combinational read, write on the rising edge.
    logic [31:0] mem [0:63];
    assign mem_read_data = mem_read_enable ? mem[mem_address[7:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model state (what registered outputs should show this cycle).
    logic [31:0] ref_mem [0:63];
    bit          m_rmw, m_c_rv, m_d_rv;
    logic [31:0] m_rmw_addr, m_rmw_data, m_c_rd, m_d_rd;
    int          m_starve;
    bit          n_rmw, n_c_rv, n_d_rv, n_wr;
    logic [31:0] n_rmw_addr, n_rmw_data, n_c_rd, n_d_rd, n_wr_data;
    logic [5:0]  n_wr_idx;
    int          n_starve;

    always @(negedge clk) begin
        int          pick;
        bit          e_cg, e_dg, e_we, e_re, chk_wd;
        logic [31:0] e_addr, e_wd, radr, rwd, old, mrg;
        logic [3:0]  rbe;
        logic        rwe;
        e_cg = 0; e_dg = 0; e_we = 0; e_re = 0; chk_wd = 1;
        e_addr = 0; e_wd = 0; radr = 0; rwd = 0; rbe = 0; rwe = 0; old = 0; mrg = 0;
        pick = 0;
        n_c_rv = 0; n_d_rv = 0; n_c_rd = m_c_rd; n_d_rd = m_d_rd;
        n_rmw = 0; n_rmw_addr = m_rmw_addr; n_rmw_data = m_rmw_data;
        n_wr = 0; n_wr_idx = 0; n_wr_data = 0; n_starve = m_starve;
        if (rst) begin
            n_c_rd = 0; n_d_rd = 0; n_starve = 0;
        end else if (m_rmw) begin
            e_we = 1; e_addr = m_rmw_addr; e_wd = m_rmw_data;
            n_wr = 1; n_wr_idx = m_rmw_addr[7:2]; n_wr_data = m_rmw_data;
            if (!d_req) n_starve = 0;
        end else begin
            if (d_req && (!c_req || m_starve == STARVE_MAX)) pick = 2;
            else if (c_req) pick = 1;
            if (pick == 1) begin rwe = c_we; radr = c_addr; rwd = c_wdata; rbe = c_be; end
            if (pick == 2) begin rwe = d_we; radr = d_addr; rwd = d_wdata; rbe = d_be; end
            if (pick != 0) begin
                e_addr = radr & 32'hFFFF_FFFC;
                if (!rwe) begin
                    e_re = 1; chk_wd = 0;
                    old = ref_mem[radr[7:2]];
                    if (pick == 1) begin n_c_rv = 1; n_c_rd = old; end
                    else begin n_d_rv = 1; n_d_rd = old; end
                end else if (rbe == 4'hF) begin
                    e_we = 1; e_wd = rwd;
                    n_wr = 1; n_wr_idx = radr[7:2]; n_wr_data = rwd;
                end else if (rbe != 4'h0) begin
                    e_re = 1; chk_wd = 0;
                    old = ref_mem[radr[7:2]];
                    for (int b = 0; b < 4; b++)
                        mrg[8*b +: 8] = rbe[b] ? rwd[8*b +: 8] : old[8*b +: 8];
                    n_rmw = 1; n_rmw_addr = e_addr; n_rmw_data = mrg;
                end else begin
                    chk_wd = 0;
                end
            end
            e_cg = (pick == 1); e_dg = (pick == 2);
            if (!d_req || pick == 2) n_starve = 0;
            else if (pick == 1 && m_starve < STARVE_MAX) n_starve = m_starve + 1;
        end
        if (chk_on) begin
            chk("c_gnt", 32'(c_gnt), 32'(e_cg));
            chk("d_gnt", 32'(d_gnt), 32'(e_dg));
            chk("mem_write_enable", 32'(mem_write_enable), 32'(e_we));
            chk("mem_read_enable", 32'(mem_read_enable), 32'(e_re));
            chk("mem_address", mem_address, e_addr);
            if (chk_wd) chk("mem_write_data", mem_write_data, e_wd);
            chk("c_rvalid", 32'(c_rvalid), 32'(m_c_rv));
            chk("d_rvalid", 32'(d_rvalid), 32'(m_d_rv));
            chk("c_rdata", c_rdata, m_c_rd);
            chk("d_rdata", d_rdata, m_d_rd);
        end
    end

    always @(posedge clk) begin
        m_rmw      <= n_rmw;
        m_rmw_addr <= n_rmw_addr;
        m_rmw_data <= n_rmw_data;
        m_c_rv     <= n_c_rv;
        m_d_rv     <= n_d_rv;
        m_c_rd     <= n_c_rd;
        m_d_rd     <= n_d_rd;
        m_starve   <= n_starve;
        if (n_wr) ref_mem[n_wr_idx] <= n_wr_data;
    end

    task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, output int waited);
        if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; d_be = be; end
        else begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wd; c_be = be; end
        waited = 0;
        while (1) begin
            @(negedge clk);
            waited++;
            if (is_d ? d_gnt : c_gnt) break;
            if (waited >= 20) begin
                chk(is_d ? "d_gnt_timeout" : "c_gnt_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        if (is_d) d_req = 0; else c_req = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [5:0] seq;
        rst = 1; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_be = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0; chk_on = 1;
        #1;
        chk("reset_c_rvalid", 32'(c_rvalid), 32'd0);
        chk("reset_c_rdata", c_rdata, 32'h0);
        chk("reset_idle_mem_address", mem_address, 32'h0);

        // Debug loader preloads memory.
        access(1, 1, 32'h08, 32'hCAFE_BABE, 4'hF, w);
        access(1, 1, 32'h0C, 32'h1111_1111, 4'hF, w);
        access(1, 1, 32'h10, 32'h55AA_55AA, 4'hF, w);

        // Full write then read-after-write on the next cycle.
        access(0, 1, 32'h04, 32'hDEAD_BEEF, 4'hF, w);
        access(0, 0, 32'h04, 32'h0, 4'h0, w);
        #1;
        chk("raw_wait", 32'(w), 32'd1);
        chk("raw_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("raw_c_rdata", c_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("c_rvalid_one_cycle", 32'(c_rvalid), 32'd0);

        // Partial store becomes read-modify-write; D request waits through RMW_WR.
        access(0, 1, 32'h08, 32'h0000_1100, 4'b0010, w);
        #1;
        chk("rmw_c_gnt", 32'(c_gnt), 32'd0);
        chk("rmw_we", 32'(mem_write_enable), 32'd1);
        chk("rmw_data", mem_write_data, 32'hCAFE_11BE);
        access(1, 0, 32'h10, 32'h0, 4'h0, w);
        chk("d_wait_rmw", 32'(w), 32'd2);
        chk("d_rdata_10", d_rdata, 32'h55AA_55AA);
        access(0, 0, 32'h08, 32'h0, 4'h0, w);
        chk("rmw_readback", c_rdata, 32'hCAFE_11BE);

        // Continuous contention: C x4, then D, then C.
        c_req = 1; c_we = 0; c_addr = 32'h04; c_be = 0;
        d_req = 1; d_we = 0; d_addr = 32'h08; d_be = 0;
        seq = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seq = {seq[4:0], d_gnt};
        end
        @(posedge clk); #1;
        c_req = 0; d_req = 0;
        chk("starve_sequence", 32'(seq), 32'b000010);
        @(posedge clk); #1;

        // Zero-byte-enable write: granted, memory untouched.
        access(1, 1, 32'h10, 32'h1234_5678, 4'h0, w);
        chk("zero_be_wait", 32'(w), 32'd1);
        access(1, 0, 32'h10, 32'h0, 4'h0, w);
        chk("zero_be_readback", d_rdata, 32'h55AA_55AA);

        // Back-to-back reads on different ports.
        c_req = 1; c_we = 0; c_addr = 32'h04;
        @(negedge clk);
        chk("b2b_c_gnt", 32'(c_gnt), 32'd1);
        @(posedge clk); #1;
        c_req = 0; d_req = 1; d_we = 0; d_addr = 32'h08;
        #1;
        chk("b2b_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("b2b_c_rdata", c_rdata, 32'hDEAD_BEEF);
        chk("b2b_d_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1;
        d_req = 0;
        #1;
        chk("b2b_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("b2b_d_rdata", d_rdata, 32'hCAFE_11BE);
        chk("b2b_c_rdata_hold", c_rdata, 32'hDEAD_BEEF);

        // Reset during RMW_WR abandons the write.
        c_req = 1; c_we = 1; c_addr = 32'h0C; c_wdata = 32'h0000_00AA; c_be = 4'b0001;
        @(negedge clk);
        chk("rst_rmw_gnt", 32'(c_gnt), 32'd1);
        @(posedge clk); #1;
        c_req = 0; rst = 1;
        #1;
        chk("rst_rmw_no_we", 32'(mem_write_enable), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("rst_c_rdata", c_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        access(0, 0, 32'h0C, 32'h0, 4'h0, w);
        chk("rst_idle_wait", 32'(w), 32'd1);
        chk("rst_mem_unchanged", c_rdata, 32'h1111_1111);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
